// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, status bit positions, sequencer states and status packing
// shared by alu_sequencer and alu_iter_muldiv.
// Build option ALU_SEQ_DIV_EN selects whether the divider exists.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    localparam int ST_ZERO  = 7;
    localparam int ST_OVF   = 6;
    localparam int ST_CARRY = 5;
    localparam int ST_NEG   = 4;
    localparam int ST_DIV0  = 2;
    localparam int ST_ILL   = 1;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    // Any error flag suppresses zero/negative/carry; the caller zeroes the data.
    function automatic logic [7:0] mk_status(input logic [31:0] data, input logic ovf,
                                             input logic carry, input logic div0,
                                             input logic ill);
        logic [7:0] s;
        s = '0;
        if (ovf || div0 || ill) begin
            s[ST_OVF]  = ovf;
            s[ST_DIV0] = div0;
            s[ST_ILL]  = ill;
        end else begin
            s[ST_ZERO]  = (data == 32'd0);
            s[ST_CARRY] = carry;
            s[ST_NEG]   = data[31];
        end
        return s;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: 32-step unsigned shift-add multiplier and restoring divider
// sharing one 64-bit accumulator. Operates on magnitudes; sign fix-up is done
// by the caller. The divide step only exists when ALU_SEQ_DIV_EN is defined.
module alu_iter_muldiv
    import alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_step,
    input  logic        i_is_div,
    input  logic [31:0] i_a_mag,
    input  logic [31:0] i_b_mag,
    output logic        o_done,
    output logic [63:0] o_acc
);

    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic [4:0]  r_cnt;
    logic [63:0] w_acc_nxt;
    logic [32:0] w_msum;
`ifdef ALU_SEQ_DIV_EN
    logic [32:0] w_rsh;
    logic [33:0] w_dsub;
`else
    logic        w_unused_is_div;
    assign w_unused_is_div = i_is_div;
`endif

    // One iteration: mul adds multiplicand into the high half then shifts right;
    // div shifts the remainder left and keeps the difference if it did not borrow.
    always_comb begin
        w_msum    = {1'b0, r_acc[63:32]} + {1'b0, r_b};
        w_acc_nxt = r_acc[0] ? {w_msum, r_acc[31:1]} : {1'b0, r_acc[63:1]};
`ifdef ALU_SEQ_DIV_EN
        w_rsh  = r_acc[63:31];
        w_dsub = {1'b0, w_rsh} - {2'b00, r_b};
        if (i_is_div)
            w_acc_nxt = w_dsub[33] ? {w_rsh[31:0], r_acc[30:0], 1'b0}
                                   : {w_dsub[31:0], r_acc[30:0], 1'b1};
`endif
    end

    // Load both modes identically (dividend / multiplier in the low half), then step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_acc <= {32'd0, i_a_mag};
            r_b   <= i_b_mag;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign o_done = i_step && (r_cnt == 5'd31);
    assign o_acc  = r_acc;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: one-at-a-time ALU with valid/ready request and result ports,
// per-result status byte and a sticky status accumulator.
// Build option ALU_SEQ_DIV_EN enables the divider; without it opcode 0100 is illegal.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [3:0]        i_req_op,
    input  logic [DATA_W-1:0] i_req_a,
    input  logic [DATA_W-1:0] i_req_b,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [DATA_W-1:0] o_res_data,
    output logic [7:0]        o_res_status,
    output logic [7:0]        o_sticky_status,
    input  logic              i_status_clr,
    output logic              o_busy
);

    state_t      r_state, w_state_nxt;
    logic        r_neg, r_is_div;
    logic [31:0] r_res_data;
    logic [7:0]  r_res_status, r_sticky;

    logic        w_accept, w_hs, w_is_mul, w_is_div, w_div0, w_ill;
    logic        w_start, w_done, w_load;
    logic [31:0] w_a_mag, w_b_mag, w_beff, w_sc_data, w_fx_data, w_ld_data;
    logic [32:0] w_usum, w_ssum;
    logic        w_sub, w_sc_ovf, w_sc_carry, w_fx_ovf;
    logic [63:0] w_acc, w_prod;
    logic [7:0]  w_ld_status;

    assign w_accept = i_req_valid && o_req_ready;
    assign w_hs     = (r_state == DONE) && i_res_ready;
    assign w_a_mag  = i_req_a[31] ? -i_req_a : i_req_a;
    assign w_b_mag  = i_req_b[31] ? -i_req_b : i_req_b;

    // Opcode decode; div falls into the illegal bucket when the divider is absent.
    always_comb begin
        w_is_mul = (i_req_op == OP_MUL);
        w_is_div = 1'b0;
        w_ill    = 1'b0;
        case (i_req_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: w_ill = 1'b0;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: w_is_div = 1'b1;
`endif
            default: w_ill = 1'b1;
        endcase
        w_div0 = w_is_div && (i_req_b == 32'd0);
    end

    // Single-cycle datapath; sub is a + ~b + 1 so carry=1 means no borrow.
    always_comb begin
        w_sub      = (i_req_op == OP_SUB);
        w_beff     = w_sub ? ~i_req_b : i_req_b;
        w_usum     = {1'b0, i_req_a} + {1'b0, w_beff} + {32'd0, w_sub};
        w_ssum     = {i_req_a[31], i_req_a} + {w_beff[31], w_beff} + {32'd0, w_sub};
        w_sc_data  = '0;
        w_sc_ovf   = 1'b0;
        w_sc_carry = 1'b0;
        case (i_req_op)
            OP_ADD, OP_SUB: begin
                w_sc_data  = w_usum[31:0];
                w_sc_ovf   = w_ssum[32] ^ w_ssum[31];
                w_sc_carry = w_usum[32];
            end
            OP_AND:  w_sc_data = i_req_a & i_req_b;
            OP_OR:   w_sc_data = i_req_a | i_req_b;
            OP_SLT:  w_sc_data = {31'd0, $signed(i_req_a) < $signed(i_req_b)};
            default: w_sc_data = '0;
        endcase
    end

    // Sign fix-up of the iterative result and its overflow check.
    always_comb begin
        w_prod    = r_neg ? (64'd0 - w_acc) : w_acc;
        w_fx_data = w_prod[31:0];
        w_fx_ovf  = (w_prod[63:31] != {33{w_prod[31]}});
`ifdef ALU_SEQ_DIV_EN
        if (r_is_div) begin
            // Only a positive 2^31 quotient (-2^31 / -1) is unrepresentable.
            w_fx_data = r_neg ? -w_acc[31:0] : w_acc[31:0];
            w_fx_ovf  = !r_neg && w_acc[31];
        end
`endif
    end

    // Next state, handshake outputs and result-register load selection.
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        o_busy      = 1'b1;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_ld_data   = '0;
        w_ld_status = '0;
        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
                if (w_accept) begin
                    if ((w_is_mul || w_is_div) && !w_div0) begin
                        w_state_nxt = ITER;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                        w_load      = 1'b1;
                        w_ld_status = mk_status(w_sc_data, w_sc_ovf, w_sc_carry, w_div0, w_ill);
                        w_ld_data   = (w_sc_ovf || w_div0 || w_ill) ? 32'd0 : w_sc_data;
                    end
                end
            end
            ITER: if (w_done) w_state_nxt = FIX;
            FIX: begin
                w_state_nxt = DONE;
                w_load      = 1'b1;
                w_ld_status = mk_status(w_fx_data, w_fx_ovf, 1'b0, 1'b0, 1'b0);
                w_ld_data   = w_fx_ovf ? 32'd0 : w_fx_data;
            end
            DONE: if (i_res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Result registers and the sign/mode captured at accept for the fix-up.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_data   <= '0;
            r_res_status <= '0;
            r_neg        <= 1'b0;
            r_is_div     <= 1'b0;
        end else begin
            if (w_load) begin
                r_res_data   <= w_ld_data;
                r_res_status <= w_ld_status;
            end
            if (w_start) begin
                r_neg    <= i_req_a[31] ^ i_req_b[31];
                r_is_div <= w_is_div;
            end
        end
    end

    // Sticky flags: clear applies first so a same-cycle delivery survives it.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sticky <= '0;
        else       r_sticky <= (i_status_clr ? 8'd0 : r_sticky) | (w_hs ? r_res_status : 8'd0);
    end

    alu_iter_muldiv u_iter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_start),
        .i_step  (r_state == ITER),
        .i_is_div(r_is_div),
        .i_a_mag (w_a_mag),
        .i_b_mag (w_b_mag),
        .o_done  (w_done),
        .o_acc   (w_acc)
    );

    assign o_res_valid     = (r_state == DONE);
    assign o_res_data      = r_res_data;
    assign o_res_status    = r_res_status;
    assign o_sticky_status = r_sticky;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors with hand-computed results for alu_sequencer.
// Divide expectations follow ALU_SEQ_DIV_EN (divider present or opcode illegal).
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst, req_valid, res_ready, status_clr, req_ready, res_valid, busy;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b, res_data;
    logic [7:0]  res_status, sticky_status;
    logic [7:0]  exp_sticky;
    int          n_chk = 0;
    int          n_pass = 0;

    alu_sequencer #(.DATA_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b), .o_res_valid(res_valid),
        .i_res_ready(res_ready), .o_res_data(res_data), .o_res_status(res_status),
        .o_sticky_status(sticky_status), .i_status_clr(status_clr), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Called at posedge+1 with the block idle; leaves at posedge+1 after accept.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = 32'hDEADBEEF; req_b = 32'h12345678;
    endtask

    task automatic wait_res(output int lat);
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        res_ready = 1'b1;
        exp_sticky = exp_sticky | res_status;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e_data,
                       input logic [7:0] e_st, input int e_lat);
        int lat;
        chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
        issue(op, a, b);
        wait_res(lat);
        chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
        chk({tag, ".data"}, res_data, e_data);
        chk({tag, ".st"}, 32'(res_status), 32'(e_st));
        take();
        chk({tag, ".sticky"}, 32'(sticky_status), 32'(exp_sticky));
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0; status_clr = 1'b0;
        req_op = 4'b0; req_a = '0; req_b = '0; exp_sticky = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.valid", 32'(res_valid), 32'd0);
        chk("rst.data", res_data, 32'd0);
        chk("rst.status", 32'(res_status), 32'd0);
        chk("rst.sticky", 32'(sticky_status), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);

        run("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h0, 8'h40, 1);
        run("add_cz",  4'b0010, 32'hFFFFFFFF, 32'h1, 32'h0, 8'hA0, 1);
        run("sub_nb",  4'b0110, 32'd5, 32'd3, 32'd2, 8'h20, 1);
        run("sub_brw", 4'b0110, 32'd3, 32'd5, 32'hFFFFFFFE, 8'h10, 1);
        run("and",     4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 8'h10, 1);
        run("or",      4'b0001, 32'h0000000F, 32'h000000F0, 32'h000000FF, 8'h00, 1);
        run("slt_t",   4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1, 8'h00, 1);
        run("slt_f",   4'b0111, 32'h1, 32'hFFFFFFFF, 32'h0, 8'h80, 1);
        run("mul_neg", 4'b0011, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 8'h10, 34);
        run("mul_ovf", 4'b0011, 32'h00010000, 32'h00010000, 32'h0, 8'h40, 34);
        run("mul_min", 4'b0011, 32'h80000000, 32'h1, 32'h80000000, 8'h10, 34);
        run("mul_nn",  4'b0011, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd15, 8'h00, 34);
`ifdef ALU_SEQ_DIV_EN
        run("div_neg", 4'b0100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 8'h10, 34);
        run("div_0",   4'b0100, 32'd5, 32'd0, 32'h0, 8'h04, 1);
        run("div_ovf", 4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'h0, 8'h40, 34);
        run("div_pos", 4'b0100, 32'd100, 32'd7, 32'd14, 8'h00, 34);
`else
        run("div_ill", 4'b0100, 32'd8, 32'd2, 32'h0, 8'h02, 1);
        run("div0_ill", 4'b0100, 32'd5, 32'd0, 32'h0, 8'h02, 1);
`endif
        run("ill_op",  4'b1111, 32'd1, 32'd2, 32'h0, 8'h02, 1);

        // Backpressure: result held for 5 cycles, then clear in the handshake cycle.
        issue(4'b0010, 32'd0, 32'd0);
        wait_res(lat);
        chk("hold.lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold.valid", 32'(res_valid), 32'd1);
            chk("hold.data", res_data, 32'd0);
            chk("hold.status", 32'(res_status), 32'h80);
            chk("hold.ready", 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1; status_clr = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0; status_clr = 1'b0;
        exp_sticky = 8'h80;
        chk("clr_hs.sticky", 32'(sticky_status), 32'h80);
        chk("clr_hs.valid", 32'(res_valid), 32'd0);

        // Reset in ITER cycle 10 of a mul abandons it.
        issue(4'b0011, 32'd3, 32'd4);
        repeat (9) begin @(posedge clk); #1; end
        chk("iter.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_sticky = '0;
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.ready", 32'(req_ready), 32'd1);
        chk("rstmid.valid", 32'(res_valid), 32'd0);
        chk("rstmid.sticky", 32'(sticky_status), 32'd0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        chk("rstmid.noresult", 32'(seen), 32'd0);
        run("post_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 8'h00, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
